// File: rtl/fu_writeback_arbiter.sv
// Shares the completion-buffer write port among the scalar FUs through one-entry
// holding registers and a round-robin arbiter that locks its grant under backpressure.
module fu_writeback_arbiter #(
    parameter int unsigned NUM_FU   = 4,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned CB_IDX_W = 4
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [NUM_FU-1:0]          fu_valid,
    output logic [NUM_FU-1:0]          fu_ready,
    input  logic [NUM_FU*DATA_W-1:0]   fu_data,
    input  logic [NUM_FU*CB_IDX_W-1:0] fu_index,
    input  logic [NUM_FU*5-1:0]        fu_rd,
    input  logic [NUM_FU-1:0]          fu_wen,
    input  logic                       flush,
    output logic                       cb_valid,
    input  logic                       cb_ready,
    output logic [$clog2(NUM_FU)-1:0]  cb_fu,
    output logic [DATA_W-1:0]          cb_data,
    output logic [CB_IDX_W-1:0]        cb_index,
    output logic [4:0]                 cb_rd,
    output logic                       cb_wen
);

    localparam int unsigned PtrW = $clog2(NUM_FU);

    logic [NUM_FU-1:0]   held_q, held_d;
    logic [DATA_W-1:0]   data_q  [NUM_FU];
    logic [CB_IDX_W-1:0] index_q [NUM_FU];
    logic [4:0]          rd_q    [NUM_FU];
    logic [NUM_FU-1:0]   wen_q;
    logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
    logic                lock_q, lock_d;
    logic [PtrW-1:0]     lock_fu_q, lock_fu_d;

    logic [NUM_FU-1:0]   capture;
    logic [PtrW-1:0]     grant;
    logic [PtrW-1:0]     cand;
    logic                found;
    logic                accept;

    // Ready depends only on held state, never on cb_ready.
    assign fu_ready = ~held_q;
    assign capture  = fu_valid & ~held_q;
    assign cb_valid = |held_q;
    assign accept   = cb_valid & cb_ready;

    always_comb begin
        grant = lock_fu_q;
        cand  = '0;
        found = 1'b0;
        if (!lock_q) begin
            grant = '0;
            for (int unsigned k = 0; k < NUM_FU; k++) begin
                cand = PtrW'((32'(rr_ptr_q) + k) % NUM_FU);
                if (!found && held_q[cand]) begin
                    grant = cand;
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        held_d    = held_q | capture;
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_fu_d = lock_fu_q;
        if (accept) begin
            held_d[grant] = 1'b0;
            rr_ptr_d      = (grant == PtrW'(NUM_FU - 1)) ? '0 : grant + PtrW'(1);
            lock_d        = 1'b0;
        end else if (cb_valid) begin
            lock_d    = 1'b1;
            lock_fu_d = grant;
        end
        // Flush squashes captures and accepts alike but keeps the fairness pointer.
        if (flush) begin
            held_d   = '0;
            lock_d   = 1'b0;
            rr_ptr_d = rr_ptr_q;
        end
    end

    always_comb begin
        cb_fu    = '0;
        cb_data  = '0;
        cb_index = '0;
        cb_rd    = '0;
        cb_wen   = 1'b0;
        if (cb_valid) begin
            cb_fu    = grant;
            cb_data  = data_q[grant];
            cb_index = index_q[grant];
            cb_rd    = rd_q[grant];
            cb_wen   = wen_q[grant];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            held_q    <= '0;
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_fu_q <= '0;
        end else begin
            held_q    <= held_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_fu_q <= lock_fu_d;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wen_q <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                data_q[i]  <= '0;
                index_q[i] <= '0;
                rd_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (capture[i] && !flush) begin
                    data_q[i]  <= fu_data[i*DATA_W +: DATA_W];
                    index_q[i] <= fu_index[i*CB_IDX_W +: CB_IDX_W];
                    rd_q[i]    <= fu_rd[i*5 +: 5];
                    wen_q[i]   <= fu_wen[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_fu_writeback_arbiter.sv
// Directed bench for fu_writeback_arbiter: stimulus queues expected CB writes,
// a negedge monitor pops and compares every accepted CB transfer.
module tb_fu_writeback_arbiter;

    logic         CLK;
    logic         nRST;
    logic [3:0]   fu_valid;
    logic [3:0]   fu_ready;
    logic [127:0] fu_data;
    logic [15:0]  fu_index;
    logic [19:0]  fu_rd;
    logic [3:0]   fu_wen;
    logic         flush;
    logic         cb_valid;
    logic         cb_ready;
    logic [1:0]   cb_fu;
    logic [31:0]  cb_data;
    logic [3:0]   cb_index;
    logic [4:0]   cb_rd;
    logic         cb_wen;

    typedef struct packed {
        logic [1:0]  fu;
        logic [31:0] data;
        logic [3:0]  idx;
        logic [4:0]  rd;
        logic        wen;
    } txn_t;

    txn_t exp_q[$];
    txn_t mon_got;
    txn_t mon_exp;
    int   checks = 0;
    int   errors = 0;

    fu_writeback_arbiter #(
        .NUM_FU   (4),
        .DATA_W   (32),
        .CB_IDX_W (4)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .fu_valid (fu_valid),
        .fu_ready (fu_ready),
        .fu_data  (fu_data),
        .fu_index (fu_index),
        .fu_rd    (fu_rd),
        .fu_wen   (fu_wen),
        .flush    (flush),
        .cb_valid (cb_valid),
        .cb_ready (cb_ready),
        .cb_fu    (cb_fu),
        .cb_data  (cb_data),
        .cb_index (cb_index),
        .cb_rd    (cb_rd),
        .cb_wen   (cb_wen)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge CLK) begin
        if (nRST && !flush && cb_valid && cb_ready) begin
            mon_got = '{fu: cb_fu, data: cb_data, idx: cb_index, rd: cb_rd, wen: cb_wen};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL cb_unexpected: got fu=%0d data=%h idx=%0d rd=%0d wen=%0d, required none",
                         mon_got.fu, mon_got.data, mon_got.idx, mon_got.rd, mon_got.wen);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL cb_txn: got fu=%0d data=%h idx=%0d rd=%0d wen=%0d, required fu=%0d data=%h idx=%0d rd=%0d wen=%0d",
                             mon_got.fu, mon_got.data, mon_got.idx, mon_got.rd, mon_got.wen,
                             mon_exp.fu, mon_exp.data, mon_exp.idx, mon_exp.rd, mon_exp.wen);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic set_fu(input int i, input logic [31:0] d, input logic [3:0] x,
                          input logic [4:0] r, input logic w);
        fu_valid[i]          = 1'b1;
        fu_data[i*32 +: 32]  = d;
        fu_index[i*4 +: 4]   = x;
        fu_rd[i*5 +: 5]      = r;
        fu_wen[i]            = w;
    endtask

    task automatic expect_txn(input logic [1:0] f, input logic [31:0] d, input logic [3:0] x,
                              input logic [4:0] r, input logic w);
        exp_q.push_back('{fu: f, data: d, idx: x, rd: r, wen: w});
    endtask

    initial begin
        nRST     = 1'b0;
        fu_valid = '0;
        fu_data  = '0;
        fu_index = '0;
        fu_rd    = '0;
        fu_wen   = '0;
        flush    = 1'b0;
        cb_ready = 1'b0;

        // Reset state
        tick();
        check("rst_fu_ready", 64'(fu_ready), 64'hF);
        check("rst_cb_valid", 64'(cb_valid), 64'h0);
        check("rst_cb_payload", {cb_fu, cb_data, cb_index, cb_rd, cb_wen}, 64'h0);
        nRST = 1'b1;
        tick();

        // T2 single ARITH result
        set_fu(0, 32'hDEADBEEF, 4'd3, 5'd5, 1'b1);
        #1;
        check("t2_no_bypass", 64'(cb_valid), 64'h0);
        tick();
        fu_valid = '0;
        check("t2_cb_valid", 64'(cb_valid), 64'h1);
        check("t2_cb_fu", 64'(cb_fu), 64'h0);
        check("t2_payload", {cb_data, cb_index, cb_rd, cb_wen}, {32'hDEADBEEF, 4'd3, 5'd5, 1'b1});
        check("t2_fu_ready", 64'(fu_ready), 64'hE);
        expect_txn(2'd0, 32'hDEADBEEF, 4'd3, 5'd5, 1'b1);
        cb_ready = 1'b1;
        tick();
        check("t2_drained", 64'(cb_valid), 64'h0);
        check("t2_ready_back", 64'(fu_ready), 64'hF);

        // T1 asynchronous reset mid-traffic (rr_ptr is 1 here)
        cb_ready = 1'b0;
        set_fu(1, 32'h11111111, 4'd1, 5'd1, 1'b1);
        set_fu(2, 32'h22222222, 4'd2, 5'd2, 1'b0);
        tick();
        fu_valid = '0;
        check("t1_pre_valid", 64'(cb_valid), 64'h1);
        #3;
        nRST = 1'b0;
        #1;
        check("t1_async_valid", 64'(cb_valid), 64'h0);
        check("t1_async_ready", 64'(fu_ready), 64'hF);
        check("t1_async_payload", {cb_fu, cb_data, cb_index, cb_rd, cb_wen}, 64'h0);
        tick();
        nRST = 1'b1;
        tick();

        // T3 all four at once; rr restarted at ARITH
        set_fu(0, 32'hA0000000, 4'd4, 5'd10, 1'b1);
        set_fu(1, 32'hB1111111, 4'd5, 5'd0,  1'b0);
        set_fu(2, 32'hC2222222, 4'd6, 5'd12, 1'b1);
        set_fu(3, 32'hD3333333, 4'd7, 5'd31, 1'b1);
        expect_txn(2'd0, 32'hA0000000, 4'd4, 5'd10, 1'b1);
        expect_txn(2'd1, 32'hB1111111, 4'd5, 5'd0,  1'b0);
        expect_txn(2'd2, 32'hC2222222, 4'd6, 5'd12, 1'b1);
        expect_txn(2'd3, 32'hD3333333, 4'd7, 5'd31, 1'b1);
        cb_ready = 1'b1;
        tick();
        fu_valid = '0;
        for (int g = 0; g < 4; g++) begin
            check("t3_grant_order", 64'(cb_fu), 64'(g));
            tick();
        end
        check("t3_drained", 64'(cb_valid), 64'h0);

        // T4 backpressure on MUL while ARITH fills (rr_ptr is 0)
        cb_ready = 1'b0;
        set_fu(1, 32'h0BADF00D, 4'd9, 5'd7, 1'b1);
        tick();
        fu_valid = '0;
        check("t4_first_fu", 64'(cb_fu), 64'h1);
        tick();
        set_fu(0, 32'h12345678, 4'd8, 5'd3, 1'b0);
        tick();
        fu_valid = '0;
        check("t4_locked_fu", 64'(cb_fu), 64'h1);
        check("t4_locked_data", 64'(cb_data), 64'h0BADF00D);
        check("t4_ready", 64'(fu_ready), 64'hC);
        tick();
        check("t4_still_locked", {cb_fu, cb_data, cb_index, cb_rd, cb_wen},
              {2'd1, 32'h0BADF00D, 4'd9, 5'd7, 1'b1});
        expect_txn(2'd1, 32'h0BADF00D, 4'd9, 5'd7, 1'b1);
        expect_txn(2'd0, 32'h12345678, 4'd8, 5'd3, 1'b0);
        cb_ready = 1'b1;
        tick();
        check("t4_wrap_arith", 64'(cb_fu), 64'h0);
        tick();
        check("t4_drained", 64'(cb_valid), 64'h0);

        // T5 fairness: park rr_ptr at 0, then ARITH keeps requesting while LS is held
        set_fu(3, 32'h55550000, 4'd10, 5'd20, 1'b1);
        expect_txn(2'd3, 32'h55550000, 4'd10, 5'd20, 1'b1);
        tick();
        fu_valid = '0;
        tick();
        check("t5_park", 64'(cb_valid), 64'h0);
        cb_ready = 1'b0;
        set_fu(0, 32'hAAAA0001, 4'd11, 5'd1, 1'b1);
        set_fu(3, 32'h55550001, 4'd12, 5'd2, 1'b1);
        tick();
        fu_valid = '0;
        cb_ready = 1'b1;
        expect_txn(2'd0, 32'hAAAA0001, 4'd11, 5'd1, 1'b1);
        expect_txn(2'd3, 32'h55550001, 4'd12, 5'd2, 1'b1);
        expect_txn(2'd0, 32'hAAAA0002, 4'd13, 5'd3, 1'b0);
        set_fu(0, 32'hAAAA0002, 4'd13, 5'd3, 1'b0);
        check("t5_first_arith", {cb_fu, cb_data}, {2'd0, 32'hAAAA0001});
        tick();
        check("t5_ls_granted", 64'(cb_fu), 64'h3);
        check("t5_ready", 64'(fu_ready), 64'h7);
        tick();
        fu_valid = '0;
        check("t5_arith_again", {cb_fu, cb_data}, {2'd0, 32'hAAAA0002});
        tick();
        check("t5_drained", 64'(cb_valid), 64'h0);

        // T6 flush with three held results and a DIV capture (rr_ptr is 1)
        cb_ready = 1'b0;
        set_fu(0, 32'hF0F00000, 4'd1, 5'd1, 1'b1);
        set_fu(1, 32'hF0F00001, 4'd2, 5'd2, 1'b1);
        set_fu(3, 32'hF0F00003, 4'd3, 5'd3, 1'b1);
        tick();
        fu_valid = '0;
        check("t6_held_ready", 64'(fu_ready), 64'h4);
        flush = 1'b1;
        set_fu(2, 32'hF0F00002, 4'd4, 5'd4, 1'b1);
        tick();
        flush    = 1'b0;
        fu_valid = '0;
        check("t6_flush_valid", 64'(cb_valid), 64'h0);
        check("t6_flush_ready", 64'(fu_ready), 64'hF);
        cb_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t6_div_dropped", 64'(cb_valid), 64'h0);
        end

        // rr_ptr survives the flush: order starts at MUL
        set_fu(0, 32'h00000100, 4'd0, 5'd0, 1'b0);
        set_fu(1, 32'h00000101, 4'd1, 5'd1, 1'b1);
        set_fu(2, 32'h00000102, 4'd2, 5'd2, 1'b0);
        set_fu(3, 32'h00000103, 4'd3, 5'd3, 1'b1);
        expect_txn(2'd1, 32'h00000101, 4'd1, 5'd1, 1'b1);
        expect_txn(2'd2, 32'h00000102, 4'd2, 5'd2, 1'b0);
        expect_txn(2'd3, 32'h00000103, 4'd3, 5'd3, 1'b1);
        expect_txn(2'd0, 32'h00000100, 4'd0, 5'd0, 1'b0);
        tick();
        fu_valid = '0;
        repeat (4) tick();
        check("t6_drained", 64'(cb_valid), 64'h0);

        tick();
        check("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
